// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared types and constants for the Winograd F(4x4,3x3) datapath
// Contents: DATA_W, tile sizes, tile typedefs, element-wise MAC state enum.
package winograd_pkg;

  localparam int DATA_W     = 16;
  localparam int TILE_IN    = 6;
  localparam int TILE_OUT   = 4;
  localparam int TILE_ELEMS = TILE_IN * TILE_IN;

  typedef logic [0:TILE_IN-1][0:TILE_IN-1][DATA_W-1:0]   tile6_t;
  typedef logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_W-1:0] tile4_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

endpackage

// File: rtl/winograd_mac_lane.sv
// rtl/winograd_mac_lane.sv - one element-wise multiply-accumulate lane
// Ports:
//   u, v   : operand elements (DATA_W)
//   acc    : current accumulator value for this element
//   first  : discard acc (start of a new channel sum)
//   sum    : (first ? 0 : acc) + low DATA_W bits of u*v
module winograd_mac_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] u,
  input  logic [DATA_W-1:0] v,
  input  logic [DATA_W-1:0] acc,
  input  logic              first,
  output logic [DATA_W-1:0] sum
);

  // Product evaluated at DATA_W width: low bits are identical for signed
  // and unsigned operands, and wrap is the intended arithmetic.
  logic [DATA_W-1:0] prod_lo;

  assign prod_lo = u * v;
  assign sum     = (first ? '0 : acc) + prod_lo;

endmodule

// File: rtl/winograd_ewmac_unit.sv
// rtl/winograd_ewmac_unit.sv - Winograd element-wise U.V accumulator across input channels
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : tile pair handshake (in_ready high only when idle)
//   in_first / in_last   : channel sequence markers, latched with the tile
//   u_in, v_in           : 6x6 transformed kernel / input tiles
//   matrix_out           : accumulated 6x6 tile M, held until the next publish
//   mult_done            : one-cycle pulse when matrix_out is newly valid
//   busy                 : high whenever not idle
module winograd_ewmac_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [0:5][0:5][DATA_W-1:0]  u_in,
  input  logic [0:5][0:5][DATA_W-1:0]  v_in,
  output logic [0:5][0:5][DATA_W-1:0]  matrix_out,
  output logic                         mult_done,
  output logic                         busy
);

  import winograd_pkg::*;

  localparam int N     = TILE_ELEMS / LANES;
  localparam int GRP_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((TILE_ELEMS % LANES) != 0) begin : g_bad_lanes
      $error("winograd_ewmac_unit: LANES must divide 36");
    end
  endgenerate

  // Tiles are kept flattened in row-major order so lane indexing is linear.
  logic [0:TILE_ELEMS-1][DATA_W-1:0] u_q;
  logic [0:TILE_ELEMS-1][DATA_W-1:0] v_q;
  logic [0:TILE_ELEMS-1][DATA_W-1:0] acc;
  logic                              first_q;
  logic                              last_q;
  logic [GRP_W-1:0]                  grp;
  logic                              grp_last;

  state_t state;
  state_t state_nxt;

  logic [5:0]        lane_idx [LANES];
  logic [DATA_W-1:0] lane_sum [LANES];

  assign grp_last = (grp == GRP_W'(N - 1));

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_idx[k] = 6'(int'(grp) * LANES + k);

      winograd_mac_lane #(
        .DATA_W (DATA_W)
      ) u_lane (
        .u     (u_q[lane_idx[k]]),
        .v     (v_q[lane_idx[k]]),
        .acc   (acc[lane_idx[k]]),
        .first (first_q),
        .sum   (lane_sum[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_MAC;
      S_MAC:   if (grp_last) state_nxt = last_q ? S_DONE : S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q        <= '0;
      v_q        <= '0;
      acc        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      grp        <= '0;
      matrix_out <= '0;
      mult_done  <= 1'b0;
    end else begin
      mult_done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            u_q     <= u_in;
            v_q     <= v_in;
            first_q <= in_first;
            last_q  <= in_last;
            grp     <= '0;
          end
        end
        S_MAC: begin
          for (int k = 0; k < LANES; k++) begin
            acc[lane_idx[k]] <= lane_sum[k];
          end
          if (!grp_last) grp <= grp + 1'b1;
        end
        S_DONE: begin
          matrix_out <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_ewmac_unit.sv
// tb/tb_winograd_ewmac_unit.sv - self-checking bench for winograd_ewmac_unit (LANES 6, 1, 36)
module tb_winograd_ewmac_unit;

  import winograd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic        in_first;
  logic        in_last;
  tile6_t      u_in;
  tile6_t      v_in;
  tile6_t      mo [3];
  logic [2:0]  rdy;
  logic [2:0]  done;
  logic [2:0]  bsy;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] model [3][36];
  tile6_t      expect_m [3];

  always #5 clk = ~clk;

  winograd_ewmac_unit #(.DATA_W(16), .LANES(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
    .in_first(in_first), .in_last(in_last), .u_in(u_in), .v_in(v_in),
    .matrix_out(mo[0]), .mult_done(done[0]), .busy(bsy[0]));

  winograd_ewmac_unit #(.DATA_W(16), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
    .in_first(in_first), .in_last(in_last), .u_in(u_in), .v_in(v_in),
    .matrix_out(mo[1]), .mult_done(done[1]), .busy(bsy[1]));

  winograd_ewmac_unit #(.DATA_W(16), .LANES(36)) dut36 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]),
    .in_first(in_first), .in_last(in_last), .u_in(u_in), .v_in(v_in),
    .matrix_out(mo[2]), .mult_done(done[2]), .busy(bsy[2]));

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic int n_of(input int sel);
    case (sel)
      0:       return 6;
      1:       return 36;
      default: return 1;
    endcase
  endfunction

  function automatic tile6_t fill(input logic [15:0] x);
    tile6_t t;
    for (int i = 0; i < 36; i++) t[i/6][i%6] = x;
    return t;
  endfunction

  function automatic tile6_t rand_tile();
    tile6_t t;
    for (int i = 0; i < 36; i++) t[i/6][i%6] = 16'($urandom);
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_tile(input string tag, input int sel);
    total_cnt++;
    assert (mo[sel] === expect_m[sel]) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s lanes_sel=%0d observed=%h expected=%h", tag, sel, mo[sel], expect_m[sel]);
    end
  endtask

  // Reference: per-element wrapping sum of U*V since the most recent first tile.
  task automatic model_tile(input int sel, input tile6_t u, input tile6_t v,
                            input bit first, input bit last);
    logic [31:0] p;
    for (int i = 0; i < 36; i++) begin
      if (first) model[sel][i] = 16'h0;
      p = u[i/6][i%6] * v[i/6][i%6];
      model[sel][i] = model[sel][i] + p[15:0];
    end
    if (last) for (int i = 0; i < 36; i++) expect_m[sel][i/6][i%6] = model[sel][i];
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 36; i++) model[s][i] = 16'h0;
      expect_m[s] = '0;
    end
  endtask

  // Called at a negedge. Presents one tile and observes the transaction until idle.
  task automatic run_tile(input string tag, input int sel, input tile6_t u, input tile6_t v,
                          input bit first, input bit last, input bit churn);
    int n;
    int guard;
    int low_cnt;
    int done_cnt;
    int done_edge;
    bit hold;
    n = n_of(sel);
    guard = 0;
    while (!rdy[sel] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_wait"}, 64'(guard < 100), 64'd1);
    u_in = u; v_in = v; in_first = first; in_last = last;
    in_valid[sel] = 1'b1;
    model_tile(sel, u, v, first, last);
    low_cnt = 0; done_cnt = 0; done_edge = -1;
    hold = churn;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (!rdy[sel]) low_cnt++;
      if (done[sel]) begin
        done_cnt++;
        done_edge = k;
      end
      if (hold && !rdy[sel]) begin
        u_in = rand_tile(); v_in = rand_tile();
        in_first = 1'($urandom); in_last = 1'($urandom);
      end else begin
        hold = 1'b0;
        in_valid[sel] = 1'b0;
      end
    end
    in_valid[sel] = 1'b0;
    check({tag, "_ready_low_cycles"}, 64'(low_cnt), 64'(last ? n + 1 : n));
    check({tag, "_done_count"}, 64'(done_cnt), 64'(last ? 1 : 0));
    if (last) begin
      check({tag, "_done_latency"}, 64'(done_edge), 64'(n + 2));
      check_tile({tag, "_matrix"}, sel);
    end
  endtask

  initial begin
    tile6_t u;
    tile6_t v;
    bit f;
    bit l;
    rst_n = 1'b0; in_valid = '0; in_first = 1'b0; in_last = 1'b0;
    u_in = '0; v_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_ready", 64'(rdy[s]), 64'd1);
      check("reset_busy", 64'(bsy[s]), 64'd0);
      check("reset_done", 64'(done[s]), 64'd0);
      check_tile("reset_matrix", s);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_tile("single", 0, fill(16'd2), fill(16'd3), 1'b1, 1'b1, 1'b0);
    check("single_value", 64'(mo[0][3][4]), 64'h0006);

    run_tile("ch1", 0, fill(16'd1), fill(16'd1), 1'b1, 1'b0, 1'b0);
    run_tile("ch2", 0, fill(16'd1), fill(16'd2), 1'b0, 1'b0, 1'b0);
    run_tile("ch3", 0, fill(16'd1), fill(16'd3), 1'b0, 1'b1, 1'b0);
    check("three_ch_value", 64'(mo[0][5][5]), 64'h0006);

    run_tile("wrap_256", 0, fill(16'h0100), fill(16'h0100), 1'b1, 1'b1, 1'b0);
    check("wrap_256_value", 64'(mo[0][0][0]), 64'h0000);
    run_tile("wrap_neg", 0, fill(16'hFFFF), fill(16'h0005), 1'b1, 1'b1, 1'b0);
    check("wrap_neg_value", 64'(mo[0][2][1]), 64'hFFFB);
    run_tile("wrap_8000a", 0, fill(16'h8000), fill(16'h0001), 1'b1, 1'b0, 1'b0);
    run_tile("wrap_8000b", 0, fill(16'h8000), fill(16'h0001), 1'b0, 1'b1, 1'b0);
    check("wrap_8000_value", 64'(mo[0][4][0]), 64'h0000);

    run_tile("last_nofirst", 0, rand_tile(), rand_tile(), 1'b0, 1'b1, 1'b0);

    run_tile("restart_a", 0, rand_tile(), rand_tile(), 1'b1, 1'b0, 1'b0);
    run_tile("restart_b", 0, rand_tile(), rand_tile(), 1'b0, 1'b0, 1'b0);
    run_tile("restart_c", 0, rand_tile(), rand_tile(), 1'b1, 1'b0, 1'b0);
    run_tile("restart_d", 0, rand_tile(), rand_tile(), 1'b0, 1'b1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      u = rand_tile(); v = rand_tile();
      f = (t == 0) || ($urandom_range(3) == 0);
      l = (t == 7) || 1'($urandom);
      run_tile("rand_l6", 0, u, v, f, l, 1'b1);
    end

    run_tile("l1_a", 1, rand_tile(), rand_tile(), 1'b1, 1'b0, 1'b1);
    run_tile("l1_b", 1, rand_tile(), rand_tile(), 1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      f = (t == 0) || 1'($urandom);
      l = (t == 3) || 1'($urandom);
      run_tile("rand_l36", 2, rand_tile(), rand_tile(), f, l, 1'b1);
    end

    // Reset during MAC: no publish, everything back to reset values.
    u_in = rand_tile(); v_in = rand_tile(); in_first = 1'b1; in_last = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int s = 0; s < 3; s++) begin
      check("rst_mid_ready", 64'(rdy[s]), 64'd1);
      check("rst_mid_busy", 64'(bsy[s]), 64'd0);
      check("rst_mid_done", 64'(done[s]), 64'd0);
      check_tile("rst_mid_matrix", s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done[0]) pulses++;
      end
      check("rst_mid_no_done", 64'(pulses), 64'd0);
    end
    check("rst_mid_ready_after", 64'(rdy[0]), 64'd1);
    run_tile("after_rst", 0, rand_tile(), rand_tile(), 1'b1, 1'b1, 1'b0);

    // Single nonzero element for the reverse transform, then hold check.
    u = '0; v = '0; u[0][0] = 16'd1; v[0][0] = 16'd1;
    run_tile("impulse", 0, u, v, 1'b1, 1'b1, 1'b0);
    check("impulse_00", 64'(mo[0][0][0]), 64'd1);
    repeat (3) @(negedge clk);
    check_tile("impulse_hold_mid", 0);
    repeat (4) @(negedge clk);
    check_tile("impulse_hold_end", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
